// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the input-conditioning debouncer:
//   - deb_state_t : debouncer FSM states
//   - DEF_*       : default parameter values used by sync_debouncer
// -----------------------------------------------------------------------------
package debounce_pkg;

  // LO/HI are the settled levels; CHK_* are the stability checks that sit
  // between them while a candidate transition is being confirmed.
  typedef enum logic [1:0] {
    LO     = 2'd0,
    CHK_HI = 2'd1,
    HI     = 2'd2,
    CHK_LO = 2'd3
  } deb_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_GLITCH_W        = 4;

endpackage

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// N-flop synchroniser bringing an asynchronous single-bit signal into clk.
// Ports:
//   clk    : clock, all flops update on its rising edge
//   rst    : synchronous active-high reset, clears every stage to 0
//   d_i    : asynchronous input
//   q_o    : synchronised output (last stage of the chain)
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] chain_q;

  // Stage 0 captures the raw input; every later stage copies its predecessor.
  // The loop runs zero times for a single-flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < N; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q_o = chain_q[N-1];

endmodule

// File: rtl/sync_debouncer.sv
// -----------------------------------------------------------------------------
// sync_debouncer
// Synchronises and debounces a raw bouncy input, producing a clean level, one-
// cycle rise/fall strobes and a saturating count of rejected transitions.
// Ports:
//   clk        : clock, all state updates on its rising edge
//   rst        : synchronous active-high reset
//   a          : raw asynchronous input
//   clean      : debounced level (registered)
//   rise       : one-cycle strobe in the first cycle clean reads 1
//   fall       : one-cycle strobe in the first cycle clean reads 0
//   glitch_cnt : saturating count of aborted transitions
// -----------------------------------------------------------------------------
module sync_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GLITCH_W        = DEF_GLITCH_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a,
  output logic                clean,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // cnt value on which a still-differing input completes the transition.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic sync;

  deb_state_t          state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic                clean_q,  clean_d;
  logic                rise_q,   rise_d;
  logic                fall_q,   fall_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  sync_chain #(
    .N (SYNC_STAGES)
  ) u_sync_chain (
    .clk (clk),
    .rst (rst),
    .d_i (a),
    .q_o (sync)
  );

  // State register: FSM state, stability counter, output level, strobes and
  // glitch counter all move together so clean and its strobe change on the
  // same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LO;
      cnt_q    <= '0;
      clean_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clean_q  <= clean_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  // Next-state logic. Strobes default low so they last exactly one cycle.
  // A CHK state either completes, keeps counting, or aborts; completion and
  // abort are mutually exclusive because they depend on opposite sync values.
  // With a one-cycle debounce window the first differing sample already
  // satisfies stability, so the stable states toggle directly.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clean_d  = clean_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;

    case (state_q)
      LO: begin
        cnt_d = '0;
        if (sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = HI;
            clean_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = CHK_HI;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      CHK_HI: begin
        if (sync) begin
          if (cnt_q == CNT_LAST) begin
            state_d = HI;
            clean_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = LO;
          cnt_d   = '0;
          if (glitch_q != GLITCH_MAX) begin
            glitch_d = glitch_q + 1'b1;
          end
        end
      end

      HI: begin
        cnt_d = '0;
        if (!sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = LO;
            clean_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = CHK_LO;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      CHK_LO: begin
        if (!sync) begin
          if (cnt_q == CNT_LAST) begin
            state_d = LO;
            clean_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = HI;
          cnt_d   = '0;
          if (glitch_q != GLITCH_MAX) begin
            glitch_d = glitch_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = LO;
        cnt_d   = '0;
        clean_d = 1'b0;
      end
    endcase
  end

  assign clean      = clean_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_sync_debouncer.sv
// -----------------------------------------------------------------------------
// tb_sync_debouncer
// Directed bench for sync_debouncer at default parameters. Inputs change 1ns
// after each rising edge and outputs are sampled at the same point, so each
// stepCycle call corresponds to one sampling edge.
// -----------------------------------------------------------------------------
module tb_sync_debouncer;

  logic       clk;
  logic       rst;
  logic       a;
  logic       clean;
  logic       rise;
  logic       fall;
  logic [3:0] glitch_cnt;

  int vectors;
  int miscompares;

  sync_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .GLITCH_W        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .clean      (clean),
    .rise       (rise),
    .fall       (fall),
    .glitch_cnt (glitch_cnt)
  );

  // Free-running 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Hold the given inputs for n edges.
  task automatic applyStimulus(input logic aVal, input logic rstVal, input int n);
    a   = aVal;
    rst = rstVal;
    for (int i = 0; i < n; i++) begin
      stepCycle();
    end
  endtask

  // Compare all four outputs as one vector against hand-derived values.
  task automatic checkOutput(input string tag, input logic expClean,
                             input logic expRise, input logic expFall,
                             input logic [3:0] expGlitch);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {clean, rise, fall, glitch_cnt};
    exp = {expClean, expRise, expFall, expGlitch};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: clean/rise/fall/glitch observed %b/%b/%b/%0d expected %b/%b/%b/%0d",
             tag, clean, rise, fall, glitch_cnt, expClean, expRise, expFall, expGlitch);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    a           = 1'b1;

    // Reset held 3 cycles with a=1: everything stays cleared.
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1);
      checkOutput($sformatf("reset_hold_%0d", k), 1'b0, 1'b0, 1'b0, 4'd0);
    end

    // Release with a=1: rise on the 6th edge, for one cycle only.
    applyStimulus(1'b1, 1'b0, 5);
    checkOutput("release_edge5", 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("release_edge6", 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("release_edge7", 1'b1, 1'b0, 1'b0, 4'd0);

    // Steady fall from clean=1: fall on the 6th edge.
    applyStimulus(1'b0, 1'b0, 5);
    checkOutput("fall_edge5", 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("fall_edge6", 1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("fall_edge7", 1'b0, 1'b0, 1'b0, 4'd0);

    // Minimum accepted pulse: a=1 for 4 edges. clean high on edges 6..9,
    // rise on 6, fall on 10, no glitch.
    for (int k = 1; k <= 12; k++) begin
      applyStimulus((k <= 4), 1'b0, 1);
      checkOutput($sformatf("minpulse_%0d", k), (k >= 6 && k <= 9),
                  (k == 6), (k == 10), 4'd0);
    end

    // Bounce: a=1 for 3 edges is rejected; the abort lands on edge 6.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus((k <= 3), 1'b0, 1);
      checkOutput($sformatf("bounce_%0d", k), 1'b0, 1'b0, 1'b0,
                  (k >= 6) ? 4'd1 : 4'd0);
    end

    // Single-cycle pulse: aborted on edge 4.
    for (int k = 1; k <= 6; k++) begin
      applyStimulus((k == 1), 1'b0, 1);
      checkOutput($sformatf("pulse1_%0d", k), 1'b0, 1'b0, 1'b0,
                  (k >= 4) ? 4'd2 : 4'd1);
    end

    // Saturation: 20 single-cycle pulses, each counted on its 4th edge,
    // the count clamps at 15.
    for (int p = 1; p <= 20; p++) begin
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 3);
      checkOutput($sformatf("sat_pulse_%0d", p), 1'b0, 1'b0, 1'b0,
                  4'((2 + p > 15) ? 15 : 2 + p));
    end
    applyStimulus(1'b0, 1'b0, 4);
    checkOutput("sat_hold", 1'b0, 1'b0, 1'b0, 4'd15);

    // Mid-check reset: two FSM edges into CHK_HI (cnt=2), then one reset
    // cycle with a=1. Glitch count is cleared, nothing new counted.
    applyStimulus(1'b1, 1'b0, 4);
    checkOutput("midchk_before", 1'b0, 1'b0, 1'b0, 4'd15);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("midchk_reset", 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 5);
    checkOutput("midchk_edge5", 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("midchk_edge6", 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("midchk_edge7", 1'b1, 1'b0, 1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
